// File: rtl/bsd_serial_framer.sv
// Serial-to-parallel framer: assembles WIDTH-bit frames from a qualified bit
// stream and hands them downstream through a one-entry valid/ready buffer.
module bsd_serial_framer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             overrun,
    input  logic             clr_ovf,
    output logic [7:0]       frame_count,
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    buf_state_t       state_r, state_s;
    logic [WIDTH-1:0] sh_r, sh_s, shifted_s;
    logic [WIDTH-1:0] word_r, word_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic             ovf_r, ovf_s;
    logic [7:0]       count_r, count_s;
    logic             done_s;
    logic             xfer_s;

    // Shift-register image once the current bit is accepted; also the completed word.
    always_comb begin
        shifted_s = {WIDTH{1'b0}};
        if (MSB_FIRST) begin
            shifted_s = {sh_r[WIDTH-2:0], bit_in};
        end else begin
            shifted_s = {bit_in, sh_r[WIDTH-1:1]};
        end
    end

    // Framing: bit counter, shift register and frame-completion strobe.
    always_comb begin
        sh_s   = sh_r;
        cnt_s  = cnt_r;
        done_s = 1'b0;
        if (frame_start) begin
            if (bit_valid) begin
                sh_s  = shifted_s;
                cnt_s = ONE_CNT;
            end else begin
                cnt_s = ZERO_CNT;
            end
        end else if (bit_valid) begin
            sh_s = shifted_s;
            if (cnt_r == LAST_CNT) begin
                cnt_s  = ZERO_CNT;
                done_s = 1'b1;
            end else begin
                cnt_s = cnt_r + ONE_CNT;
            end
        end else begin
            sh_s = sh_r;
        end
    end

    // Output buffer FSM, overrun flag and delivered-frame counter.
    always_comb begin
        state_s = state_r;
        word_s  = word_r;
        ovf_s   = ovf_r;
        count_s = count_r;
        xfer_s  = (state_r == BUF_FULL) && word_ready;
        if (xfer_s) begin
            count_s = count_r + 8'd1;
        end else begin
            count_s = count_r;
        end
        case (state_r)
            BUF_EMPTY: begin
                if (done_s) begin
                    state_s = BUF_FULL;
                    word_s  = shifted_s;
                end else begin
                    state_s = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (done_s && xfer_s) begin
                    word_s = shifted_s;
                end else if (xfer_s) begin
                    state_s = BUF_EMPTY;
                end else begin
                    state_s = BUF_FULL;
                end
            end
            default: begin
                state_s = BUF_EMPTY;
            end
        endcase
        // A dropped frame beats a simultaneous clear.
        if (done_s && (state_r == BUF_FULL) && !word_ready) begin
            ovf_s = 1'b1;
        end else if (clr_ovf) begin
            ovf_s = 1'b0;
        end else begin
            ovf_s = ovf_r;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= BUF_EMPTY;
            sh_r    <= {WIDTH{1'b0}};
            cnt_r   <= ZERO_CNT;
            word_r  <= {WIDTH{1'b0}};
            ovf_r   <= 1'b0;
            count_r <= 8'd0;
        end else begin
            state_r <= state_s;
            sh_r    <= sh_s;
            cnt_r   <= cnt_s;
            word_r  <= word_s;
            ovf_r   <= ovf_s;
            count_r <= count_s;
        end
    end

    assign word_out    = word_r;
    assign word_valid  = (state_r == BUF_FULL);
    assign overrun     = ovf_r;
    assign frame_count = count_r;
    assign busy        = (cnt_r != ZERO_CNT);

endmodule

// File: tb/tb_bsd_serial_framer.sv
// Bench for bsd_serial_framer: MSB-first and LSB-first instances share one
// stimulus stream and are compared every cycle against a frame-level model.
module tb_bsd_serial_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, bit_in, bit_valid, frame_start, word_ready, clr_ovf;
    logic [7:0] wo_a, wo_b, fc_a, fc_b;
    logic       wv_a, wv_b, ov_a, ov_b, busy_a, busy_b;

    bsd_serial_framer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .word_out(wo_a), .word_valid(wv_a),
        .word_ready(word_ready), .overrun(ov_a), .clr_ovf(clr_ovf),
        .frame_count(fc_a), .busy(busy_a)
    );

    bsd_serial_framer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .word_out(wo_b), .word_valid(wv_b),
        .word_ready(word_ready), .overrun(ov_b), .clr_ovf(clr_ovf),
        .frame_count(fc_b), .busy(busy_b)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Frame-level model: list of bits received so far, one buffered word per bit order.
    int         m_nbits = 0;
    bit         m_bits[8];
    bit         m_valid = 1'b0;
    bit         m_ovf   = 1'b0;
    int         m_count = 0;
    logic [7:0] m_word_msb = 8'h00;
    logic [7:0] m_word_lsb = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit         done;
        bit         xfer;
        logic [7:0] wm, wl;
        if (!rst_n) begin
            m_nbits = 0; m_valid = 1'b0; m_ovf = 1'b0; m_count = 0;
            m_word_msb = 8'h00; m_word_lsb = 8'h00;
            return;
        end
        done = 1'b0;
        wm = 8'h00;
        wl = 8'h00;
        if (frame_start) m_nbits = 0;
        if (bit_valid) begin
            m_bits[m_nbits] = bit_in;
            m_nbits++;
            if (m_nbits == 8) begin
                done = 1'b1;
                m_nbits = 0;
                for (int i = 0; i < 8; i++) begin
                    wm[7-i] = m_bits[i];
                    wl[i]   = m_bits[i];
                end
            end
        end
        xfer = m_valid && word_ready;
        if (xfer) m_count = (m_count + 1) % 256;
        if (clr_ovf) m_ovf = 1'b0;
        if (done) begin
            if (!m_valid || xfer) begin
                m_word_msb = wm;
                m_word_lsb = wl;
                m_valid = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (xfer) begin
            m_valid = 1'b0;
        end
    endtask

    // Compare both instances against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("word_out_msb", wo_a, m_word_msb);
            check("word_out_lsb", wo_b, m_word_lsb);
            check("word_valid_a", wv_a, m_valid);
            check("word_valid_b", wv_b, m_valid);
            check("overrun_a", ov_a, m_ovf);
            check("overrun_b", ov_b, m_ovf);
            check("frame_count_a", fc_a, m_count);
            check("frame_count_b", fc_b, m_count);
            check("busy_a", busy_a, m_nbits != 0);
            check("busy_b", busy_b, m_nbits != 0);
        end
    end

    task automatic cyc(input bit r, input bit bv, input bit b, input bit fs,
                       input bit rdy, input bit clr);
        rst_n = r; bit_valid = bv; bit_in = b; frame_start = fs;
        word_ready = rdy; clr_ovf = clr;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v, input bit rdy);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, v[7-i], 1'b0, rdy, 1'b0);
    endtask

    task automatic idle(input bit rdy);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        logic [7:0] v;
        rst_n = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; frame_start = 1'b0;
        word_ready = 1'b0; clr_ovf = 1'b0;
        @(negedge clk);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        check("rst_word_out", wo_a, 32'h0);
        check("rst_word_valid", wv_a, 32'h0);
        check("rst_frame_count", fc_a, 32'h0);
        check("rst_busy", busy_a, 32'h0);

        // Palindromic pattern 0xBD, both bit orders.
        send_byte(8'hBD, 1'b1);
        check("bd_valid", wv_a, 32'h1);
        check("bd_word_msb", wo_a, 32'hBD);
        check("bd_word_lsb", wo_b, 32'hBD);
        idle(1'b1);
        check("bd_valid_one_cycle", wv_a, 32'h0);
        check("bd_count", fc_a, 32'h1);

        // 1 followed by seven 0s: 0x80 MSB-first, 0x01 LSB-first.
        send_byte(8'h80, 1'b1);
        check("b80_word_msb", wo_a, 32'h80);
        check("b80_word_lsb", wo_b, 32'h01);
        idle(1'b1);

        // Partial frame discarded by frame_start carrying the first bit of 0xA5.
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("busy_after_first_bit", busy_a, 32'h1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        v = 8'hA5;
        cyc(1'b1, 1'b1, v[7], 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) cyc(1'b1, 1'b1, v[7-i], 1'b0, 1'b1, 1'b0);
        check("a5_valid", wv_a, 32'h1);
        check("a5_word", wo_a, 32'hA5);
        idle(1'b1);
        check("a5_only_frame", fc_a, 32'h3);

        // Overrun: 0x3C held, 0xFF dropped, then cleared.
        send_byte(8'h3C, 1'b0);
        send_byte(8'hFF, 1'b0);
        check("ovr_word_kept", wo_a, 32'h3C);
        check("ovr_flag", ov_a, 32'h1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_cleared", ov_a, 32'h0);
        idle(1'b1);

        // Transfer and completion in the same cycle: no overrun.
        send_byte(8'h11, 1'b0);
        v = 8'h22;
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, v[7-i], 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, v[0], 1'b0, 1'b1, 1'b0);
        check("swap_word", wo_a, 32'h22);
        check("swap_valid", wv_a, 32'h1);
        check("swap_no_ovr", ov_a, 32'h0);
        idle(1'b1);
        check("swap_count", fc_a, 32'h6);

        // 256 back-to-back transfers from reset wrap frame_count to 0.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int f = 0; f < 256; f++) send_byte(8'($urandom), 1'b1);
        check("wrap_pre", fc_a, 32'd255);
        idle(1'b1);
        check("wrap_zero", fc_a, 32'h0);

        // Reset with buffer full and a partial frame held.
        send_byte(8'h5A, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, i[0], 1'b0, 1'b0, 1'b0);
        check("midframe_busy", busy_a, 32'h1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("mid_rst_busy", busy_a, 32'h0);
        check("mid_rst_word", wo_a, 32'h0);
        check("mid_rst_valid", wv_a, 32'h0);
        check("mid_rst_count", fc_a, 32'h0);
        send_byte(8'hC3, 1'b1);
        check("fresh_frame", wo_a, 32'hC3);
        idle(1'b1);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
